// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width defaults and the fetch FSM state type.
package cpu_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_WIDTH      = 32;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word addresses to a synchronous program
// memory (one-cycle read latency) and registers the returned word into IF/ID.
//
// state | meaning
// BOOT  | first cycle after reset, RESET_PC is being issued
// RUN   | streaming one word per cycle, stall re-issues the in-flight address
// HALT  | no new fetches; only a redirect restarts the stream
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    WIDTH      = DEF_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] pm_addr_o,
    input  logic [WIDTH-1:0]      pm_instr_i,
    output logic                  if_id_valid_o,
    output logic [ADDR_WIDTH-1:0] if_id_pc_o,
    output logic [WIDTH-1:0]      if_id_instr_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  resp_valid;

    // Address mux: a redirect must reach memory this cycle; a stall re-reads
    // the in-flight word so pm_instr_i still holds it when the stall lifts.
    always_comb begin
        pm_addr_o = pc_q;
        if (redirect_i) begin
            pm_addr_o = redirect_pc_i;
        end else if (stall_i) begin
            pm_addr_o = pc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; redirect overrides everything and resumes streaming.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_BOOT: state_next = FETCH_RUN;
            FETCH_RUN:  if (halt_i) state_next = FETCH_HALT;
            FETCH_HALT: state_next = FETCH_HALT;
            default:    state_next = FETCH_BOOT;
        endcase
        if (redirect_i) begin
            state_next = FETCH_RUN;
        end
    end

    // PC pipeline and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pc_d          <= RESET_PC;
            resp_valid    <= 1'b0;
            if_id_valid_o <= 1'b0;
            if_id_pc_o    <= '0;
            if_id_instr_o <= '0;
        end else if (redirect_i) begin
            // The word arriving now is wrong-path; squash it.
            pc_d          <= redirect_pc_i;
            pc_q          <= redirect_pc_i + PC_ONE;
            resp_valid    <= 1'b1;
            if_id_valid_o <= 1'b0;
        end else begin
            case (state)
                FETCH_BOOT: begin
                    pc_d       <= RESET_PC;
                    pc_q       <= RESET_PC + PC_ONE;
                    resp_valid <= 1'b1;
                end
                FETCH_RUN: begin
                    if (!stall_i) begin
                        if_id_valid_o <= resp_valid;
                        if_id_pc_o    <= pc_d;
                        if_id_instr_o <= pm_instr_i;
                        if (halt_i) begin
                            resp_valid <= 1'b0;
                        end else begin
                            pc_d       <= pc_q;
                            pc_q       <= pc_q + PC_ONE;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                FETCH_HALT: begin
                    // A word held by a stall that coincided with halt still
                    // has resp_valid set and is delivered here exactly once.
                    if (!stall_i) begin
                        if_id_valid_o <= resp_valid;
                        if_id_pc_o    <= pc_d;
                        if_id_instr_o <= pm_instr_i;
                        resp_valid    <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word-address width of program_memory.
REQ-002 Parameter WIDTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first word address fetched after reset.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 Port stall_i  input  1  decode cannot accept; hold IF/ID.
REQ-007 Port redirect_i  input  1  branch/jump taken; refetch from redirect_pc_i.
REQ-008 Port redirect_pc_i  input  ADDR_WIDTH  redirect target word address.
REQ-009 Port halt_i  input  1  stop issuing fetches.
REQ-010 Port pm_addr_o  output  ADDR_WIDTH  address to program_memory; its instruction returns one cycle later.
REQ-011 Port pm_instr_i  input  WIDTH  program_memory instruction output.
REQ-012 Port if_id_valid_o  output  1  IF/ID holds a live instruction.
REQ-013 Port if_id_pc_o  output  ADDR_WIDTH  word address of if_id_instr_o.
REQ-014 Port if_id_instr_o  output  WIDTH  fetched instruction.

Function
REQ-015 Internal state: pc_q (next address to issue), pc_d (address in flight), resp_valid (pm_instr_i is a live response this cycle), FSM state.
REQ-016 FSM states BOOT, RUN, HALT; BOOT -> RUN after one cycle; RUN -> HALT when halt_i=1 and redirect_i=0; HALT -> RUN only on redirect_i=1.
REQ-017 pm_addr_o priority: redirect_i=1 -> redirect_pc_i; else stall_i=1 -> pc_d; else pc_q (combinational mux).
REQ-018 BOOT: issues pm_addr_o=pc_q=RESET_PC; next edge pc_d<=RESET_PC, pc_q<=RESET_PC+1, resp_valid<=1.
REQ-019 RUN, no stall, no redirect: pc_d<=pc_q, pc_q<=pc_q+1, resp_valid<=1; IF/ID loads {resp_valid, pc_d, pm_instr_i}.
REQ-020 Stall (no redirect): pc_q, pc_d, resp_valid, IF/ID all hold; re-issuing pc_d keeps pm_instr_i equal to the in-flight word, so no word is lost or duplicated on release.
REQ-021 Redirect (any state, overrides stall and halt): pc_d<=redirect_pc_i, pc_q<=redirect_pc_i+1, resp_valid<=1, if_id_valid_o<=0 (wrong-path word squashed); FSM -> RUN.
REQ-022 Entering HALT: resp_valid<=0 at that edge; IF/ID still loads the in-flight word if not stalled; no further valid words until redirect.
REQ-023 HALT: pm_addr_o=pc_q held, pc_q/pc_d frozen, if_id_valid_o<=0 on every non-stalled edge.
REQ-024 Address arithmetic is modulo 2**ADDR_WIDTH; pc_q=2**ADDR_WIDTH-1 wraps to 0 with no flag.
REQ-025 Throughput one instruction per cycle in RUN without stall; first valid IF/ID two edges after reset release.
REQ-026 Simultaneous stall_i and halt_i in RUN: stall holds datapath, FSM still -> HALT; resp_valid stays 1 so the held word is delivered on release.

Reset
REQ-027 rst_n=0 asynchronously forces: FSM=BOOT, pc_q=RESET_PC, pc_d=RESET_PC, resp_valid=0, if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=0.
REQ-028 Reset mid-stall or mid-redirect discards all in-flight state; fetch restarts at RESET_PC.
REQ-029 pm_addr_o during reset equals RESET_PC.

Structure
REQ-030 Shared package cpu_pkg holds ADDR_WIDTH, WIDTH defaults and the fetch FSM enum type.
REQ-031 No sub-module; program_memory is instantiated beside instruction_fetch in the pipelined top, not inside it.

Verification
REQ-032 Reset release with memory word n = 32'h1000_0000+n -> if_id {valid=1, pc=0, instr=32'h1000_0000} at edge 2, then pc 1,2,3 on consecutive edges.
REQ-033 stall_i high 3 cycles while IF/ID holds pc=5 -> IF/ID stays pc=5 for 3 edges, then pc=6,7 with no skip or repeat.
REQ-034 redirect_i with redirect_pc_i=12'h100 while IF/ID holds pc=8 -> next edge if_id_valid_o=0, following edge {valid=1, pc=12'h100}, then 12'h101.
REQ-035 redirect_i and stall_i together -> redirect wins; sequence identical to REQ-034.
REQ-036 RESET_PC=12'hFFE -> IF/ID pc sequence FFE, FFF, 000, 001.
REQ-037 halt_i pulse at pc_q=4 -> IF/ID delivers pc=3 then valid=0 indefinitely; redirect to 12'h020 resumes with pc=12'h020.
